// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing defaults and RGB332 -> 8:8:8 colour expansion.
// No state: constants, types and a pure function only.
package vga_timing_pkg;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;
   localparam int DEF_PIPE_LAT = 2;

   localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
   localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

   typedef struct packed {
      logic [2:0] r;
      logic [2:0] g;
      logic [1:0] b;
   } rgb332_t;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb888_t;

   // Bit replication keeps full black and full white at the ends of the 8-bit range.
   function automatic rgb888_t rgb332_to_888(input rgb332_t c);
      rgb888_t o;
      o.r = {c.r, c.r, c.r[2:1]};
      o.g = {c.g, c.g, c.g[2:1]};
      o.b = {4{c.b}};
      return o;
   endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Enabled shift register with a synchronous reset value; DEPTH enabled ticks latency.
// No backpressure: every stage holds while en is low.
module vga_delay_line #(
   parameter int               WIDTH   = 3,
   parameter int               DEPTH   = 2,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             resetN,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [DEPTH-1:0][WIDTH-1:0] stage;

   always_ff @(posedge clk) begin
      if (!resetN) begin
         for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
      end else if (en) begin
         stage[0] <= d;
         for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
   end

   assign q = stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_out.sv
// VGA raster counters plus sync/blank/colour output stage; outputs trail pixelX/Y by PIPE_LAT+1 pixEn ticks.
// No backpressure: all state, outputs included, holds while pixEn is low.
module vga_timing_out
   import vga_timing_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP,
   parameter int PIPE_LAT = DEF_PIPE_LAT
) (
   input  logic        clk,
   input  logic        resetN,
   input  logic        pixEn,
   input  logic [7:0]  RGBIn,
   output logic [10:0] pixelX,
   output logic [10:0] pixelY,
   output logic        startOfFrame,
   output logic        oVGA_HS,
   output logic        oVGA_VS,
   output logic        oVGA_BLANK_N,
   output logic [7:0]  oVGA_R,
   output logic [7:0]  oVGA_G,
   output logic [7:0]  oVGA_B
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
   localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
   localparam logic [10:0] H_VIS      = 11'(H_ACTIVE);
   localparam logic [10:0] V_VIS      = 11'(V_ACTIVE);
   localparam logic [10:0] HS_START   = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [10:0] VS_START   = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] VS_END     = 11'(V_ACTIVE + V_FP + V_SYNC);

   logic [10:0] h_cnt, v_cnt;
   logic        h_last, v_last;
   logic        active, hs_raw, vs_raw;
   logic [2:0]  tim_q;
   rgb888_t     px888;

   assign h_last = (h_cnt == H_LAST);
   assign v_last = (v_cnt == V_LAST);

   always_ff @(posedge clk) begin
      if (!resetN) begin
         h_cnt        <= '0;
         v_cnt        <= '0;
         startOfFrame <= 1'b0;
      end else begin
         // A single-clk pulse, so it clears on the very next clk even when pixEn is low.
         startOfFrame <= pixEn && h_last && v_last;
         if (pixEn) begin
            if (h_last) begin
               h_cnt <= '0;
               v_cnt <= v_last ? '0 : v_cnt + 1'b1;
            end else begin
               h_cnt <= h_cnt + 1'b1;
            end
         end
      end
   end

   assign pixelX = h_cnt;
   assign pixelY = v_cnt;

   always_comb begin
      active = (h_cnt < H_VIS) && (v_cnt < V_VIS);
      hs_raw = !((h_cnt >= HS_START) && (h_cnt < HS_END));
      vs_raw = !((v_cnt >= VS_START) && (v_cnt < VS_END));
   end

   // Timing travels alongside the object pipeline so it meets the matching RGBIn.
   vga_delay_line #(
      .WIDTH   (3),
      .DEPTH   (PIPE_LAT),
      .RST_VAL (3'b110)
   ) u_delay (
      .clk    (clk),
      .resetN (resetN),
      .en     (pixEn),
      .d      ({hs_raw, vs_raw, active}),
      .q      (tim_q)
   );

   always_comb px888 = rgb332_to_888(rgb332_t'(RGBIn));

   always_ff @(posedge clk) begin
      if (!resetN) begin
         oVGA_HS      <= 1'b1;
         oVGA_VS      <= 1'b1;
         oVGA_BLANK_N <= 1'b0;
         oVGA_R       <= '0;
         oVGA_G       <= '0;
         oVGA_B       <= '0;
      end else if (pixEn) begin
         oVGA_HS      <= tim_q[2];
         oVGA_VS      <= tim_q[1];
         oVGA_BLANK_N <= tim_q[0];
         oVGA_R       <= tim_q[0] ? px888.r : 8'h00;
         oVGA_G       <= tim_q[0] ? px888.g : 8'h00;
         oVGA_B       <= tim_q[0] ? px888.b : 8'h00;
      end
   end

endmodule

// File: tb/tb_vga_timing_out.sv
// Bench for vga_timing_out: directed stimulus per clk edge, expected values queued by edge number.
// Vertical timing is shrunk to 8 lines so whole frames fit in a short run; horizontal stays 640x480@60.
module tb_vga_timing_out;

   localparam int BASE   = 5;              // reset edges 1..BASE; tick t lands on edge BASE+t
   localparam int C0     = BASE + 12810;   // start of the pixEn-gating section
   localparam int E_RST  = C0 + 311;       // mid-frame reset edge
   localparam int END_CY = E_RST + 700;

   localparam int S_X = 0, S_Y = 1, S_HS = 2, S_VS = 3, S_BLK = 4,
                  S_R = 5, S_G = 6, S_B = 7, S_SOF = 8;

   logic        clk;
   logic        resetN;
   logic        pixEn;
   logic [7:0]  RGBIn;
   logic [10:0] pixelX, pixelY;
   logic        startOfFrame, oVGA_HS, oVGA_VS, oVGA_BLANK_N;
   logic [7:0]  oVGA_R, oVGA_G, oVGA_B;

   typedef struct {
      int    cyc;
      int    sel;
      int    val;
      string name;
   } exp_t;

   typedef struct {
      int         cyc;
      logic [7:0] v;
   } rgb_vec_t;

   exp_t     sb[$];
   rgb_vec_t rgb_tab[$];
   int       cyc       = 0;
   int       n_cmp     = 0;
   int       n_err     = 0;
   bit       stim_done = 1'b0;

   vga_timing_out #(
      .V_ACTIVE (4),
      .V_FP     (1),
      .V_SYNC   (2),
      .V_BP     (1),
      .PIPE_LAT (2)
   ) dut (
      .clk          (clk),
      .resetN       (resetN),
      .pixEn        (pixEn),
      .RGBIn        (RGBIn),
      .pixelX       (pixelX),
      .pixelY       (pixelY),
      .startOfFrame (startOfFrame),
      .oVGA_HS      (oVGA_HS),
      .oVGA_VS      (oVGA_VS),
      .oVGA_BLANK_N (oVGA_BLANK_N),
      .oVGA_R       (oVGA_R),
      .oVGA_G       (oVGA_G),
      .oVGA_B       (oVGA_B)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void push_exp(input int c, input int sel, input int val, input string nm);
      exp_t e;
      int   i;
      e.cyc  = c;
      e.sel  = sel;
      e.val  = val;
      e.name = nm;
      i = sb.size();
      while (i > 0 && sb[i-1].cyc > c) i--;
      sb.insert(i, e);
   endfunction

   function automatic void push_rgb(input int c, input int r, input int g, input int b, input string nm);
      push_exp(c, S_R, r, {nm, "_r"});
      push_exp(c, S_G, g, {nm, "_g"});
      push_exp(c, S_B, b, {nm, "_b"});
   endfunction

   function automatic void drive_rgb(input int c, input logic [7:0] v);
      rgb_vec_t r;
      r.cyc = c;
      r.v   = v;
      rgb_tab.push_back(r);
   endfunction

   function automatic int actual(input int sel);
      case (sel)
         S_X:     return int'(pixelX);
         S_Y:     return int'(pixelY);
         S_HS:    return int'(oVGA_HS);
         S_VS:    return int'(oVGA_VS);
         S_BLK:   return int'(oVGA_BLANK_N);
         S_R:     return int'(oVGA_R);
         S_G:     return int'(oVGA_G);
         S_B:     return int'(oVGA_B);
         S_SOF:   return int'(startOfFrame);
         default: return -1;
      endcase
   endfunction

   function automatic logic [7:0] rgb_at(input int c);
      foreach (rgb_tab[i]) if (rgb_tab[i].cyc == c) return rgb_tab[i].v;
      return 8'h00;
   endfunction

   function automatic void build_expectations();
      // reset state
      push_exp(BASE, S_X, 0, "rst_x");
      push_exp(BASE, S_Y, 0, "rst_y");
      push_exp(BASE, S_HS, 1, "rst_hs");
      push_exp(BASE, S_VS, 1, "rst_vs");
      push_exp(BASE, S_BLK, 0, "rst_blank");
      push_rgb(BASE, 0, 0, 0, "rst");
      push_exp(BASE, S_SOF, 0, "rst_sof");
      push_exp(BASE + 1, S_X, 1, "first_tick_x");
      push_exp(BASE + 1, S_SOF, 0, "no_sof_after_reset");
      // first visible pixel reaches the pins on tick 3; tick 2 still shows the reset-loaded pipeline
      drive_rgb(BASE + 2, 8'hFF);
      push_rgb(BASE + 2, 0, 0, 0, "pre_pipe");
      push_exp(BASE + 2, S_BLK, 0, "pre_pipe_blank");
      drive_rgb(BASE + 3, 8'hFF);
      push_rgb(BASE + 3, 8'hFF, 8'hFF, 8'hFF, "first_px");
      push_exp(BASE + 3, S_BLK, 1, "first_px_blank");
      // BLANK_N edges on line 1
      push_exp(BASE + 802, S_BLK, 0, "blank_lead_lo");
      push_exp(BASE + 803, S_BLK, 1, "blank_lead_hi");
      push_exp(BASE + 1442, S_BLK, 1, "blank_tail_hi");
      push_exp(BASE + 1443, S_BLK, 0, "blank_tail_lo");
      // HS low for exactly 96 ticks, first low at pixelX=659
      push_exp(BASE + 1458, S_HS, 1, "hs_before");
      push_exp(BASE + 1459, S_HS, 0, "hs_first_low");
      push_exp(BASE + 1459, S_X, 659, "hs_first_low_x");
      push_exp(BASE + 1554, S_HS, 0, "hs_last_low");
      push_exp(BASE + 1555, S_HS, 1, "hs_after");
      // colour expansion on line 1
      drive_rgb(BASE + 903, 8'hE0);
      push_rgb(BASE + 903, 8'hFF, 8'h00, 8'h00, "red");
      drive_rgb(BASE + 904, 8'h03);
      push_rgb(BASE + 904, 8'h00, 8'h00, 8'hFF, "blue");
      drive_rgb(BASE + 905, 8'h1C);
      push_rgb(BASE + 905, 8'h00, 8'hFF, 8'h00, "green");
      drive_rgb(BASE + 906, 8'hA5);
      push_rgb(BASE + 906, 8'hB6, 8'h24, 8'h55, "mixed_a5");
      drive_rgb(BASE + 1500, 8'hFF);
      push_rgb(BASE + 1500, 0, 0, 0, "hblank_ff");
      push_exp(BASE + 1500, S_BLK, 0, "hblank_blank");
      drive_rgb(BASE + 4103, 8'hFF);
      push_rgb(BASE + 4103, 0, 0, 0, "vblank_ff");
      push_exp(BASE + 4103, S_BLK, 0, "vblank_blank");
      // VS low for exactly 2 lines
      push_exp(BASE + 4002, S_VS, 1, "vs_before");
      push_exp(BASE + 4003, S_VS, 0, "vs_first_low");
      push_exp(BASE + 5602, S_VS, 0, "vs_last_low");
      push_exp(BASE + 5603, S_VS, 1, "vs_after");
      // frame wrap and startOfFrame period
      push_exp(BASE + 6399, S_X, 799, "last_x");
      push_exp(BASE + 6399, S_Y, 7, "last_y");
      push_exp(BASE + 6399, S_SOF, 0, "sof_pre");
      push_exp(BASE + 6400, S_X, 0, "wrap_x");
      push_exp(BASE + 6400, S_Y, 0, "wrap_y");
      push_exp(BASE + 6400, S_SOF, 1, "sof_1");
      push_exp(BASE + 6401, S_SOF, 0, "sof_1_width");
      push_exp(BASE + 12799, S_SOF, 0, "sof_2_pre");
      push_exp(BASE + 12800, S_SOF, 1, "sof_2");
      // pixEn every 2nd clk, then frozen for 10 clk
      push_exp(C0 + 1, S_X, 10, "gate_idle_x");
      push_exp(C0 + 2, S_X, 11, "gate_tick_x");
      drive_rgb(C0 + 20, 8'hE0);
      push_exp(C0 + 20, S_X, 20, "gate_end_x");
      push_exp(C0 + 20, S_R, 8'hFF, "gate_end_r");
      for (int c = C0 + 21; c <= C0 + 30; c++) drive_rgb(c, 8'h1C);
      push_exp(C0 + 21, S_X, 20, "freeze_start_x");
      push_exp(C0 + 30, S_X, 20, "freeze_end_x");
      push_exp(C0 + 30, S_Y, 0, "freeze_end_y");
      push_exp(C0 + 30, S_R, 8'hFF, "freeze_r");
      push_exp(C0 + 30, S_G, 0, "freeze_g");
      push_exp(C0 + 30, S_BLK, 1, "freeze_blank");
      push_exp(C0 + 31, S_X, 21, "resume_x");
      push_exp(C0 + 31, S_R, 0, "resume_r");
      // mid-frame reset at pixelX=300
      push_exp(E_RST - 1, S_X, 300, "pre_rst_x");
      push_exp(E_RST - 1, S_BLK, 1, "pre_rst_blank");
      push_exp(E_RST, S_X, 0, "mid_rst_x");
      push_exp(E_RST, S_Y, 0, "mid_rst_y");
      push_exp(E_RST, S_HS, 1, "mid_rst_hs");
      push_exp(E_RST, S_BLK, 0, "mid_rst_blank");
      push_exp(E_RST, S_SOF, 0, "mid_rst_sof");
      push_exp(E_RST + 1, S_X, 1, "restart_x");
      push_exp(E_RST + 3, S_BLK, 1, "restart_blank");
      push_exp(E_RST + 658, S_HS, 1, "restart_hs_before");
      push_exp(E_RST + 659, S_HS, 0, "restart_hs_low");
      push_exp(E_RST + 659, S_X, 659, "restart_hs_x");
   endfunction

   // Stimulus: inputs for edge c are set at the falling edge before it.
   initial begin
      resetN = 1'b0;
      pixEn  = 1'b1;
      RGBIn  = 8'h00;
      build_expectations();
      for (int c = 1; c <= END_CY; c++) begin
         resetN = !(c <= BASE || c == E_RST);
         if (c > C0 && c <= C0 + 20)           pixEn = ((c - C0) % 2 == 0);
         else if (c > C0 + 20 && c <= C0 + 30) pixEn = 1'b0;
         else                                  pixEn = 1'b1;
         RGBIn = rgb_at(c);
         @(negedge clk);
      end
      stim_done = 1'b1;
   end

   // Monitor: after each edge, pop every expectation due at that edge and compare.
   initial begin
      exp_t e;
      int   a;
      while (!stim_done) begin
         @(posedge clk);
         cyc++;
         #1;
         while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            n_cmp++;
            if (e.cyc < cyc) begin
               n_err++;
               $display("FAIL %s: due at edge %0d, not reached (now %0d)", e.name, e.cyc, cyc);
            end else begin
               a = actual(e.sel);
               if (a != e.val) begin
                  n_err++;
                  $display("FAIL %s @edge %0d: got 0x%0h, expected 0x%0h", e.name, cyc, a, e.val);
               end
            end
         end
      end
      while (sb.size() > 0) begin
         e = sb.pop_front();
         n_cmp++;
         n_err++;
         $display("FAIL %s: never checked (due at edge %0d)", e.name, e.cyc);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
